// File: rtl/qspi_matmul_host.sv
// QSPI host for the 2x2 byte matrix-multiply target: writes A,B (16 nibbles), reads C (8 nibbles).
// Optional self-check of the returned bytes: define QSPI_HOST_CHECK_EN to add the mismatch port.
module qspi_matmul_host #(
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        qspi_clk_o,
  output logic        qspi_cs_n_o,
  output logic [3:0]  qspi_io_o,
  output logic [3:0]  qspi_io_oe,
  input  logic [3:0]  qspi_io_i
`ifdef QSPI_HOST_CHECK_EN
  ,
  output logic        mismatch
`endif
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_TX    = 3'd2;
  localparam logic [2:0] S_RX    = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP_CYC - 1);
  localparam logic [15:0] GAP_M1   = 16'(CS_GAP_CYC - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [4:0]  edge_cnt;
  logic [63:0] ops;
  logic [31:0] rx_sh;
  logic [31:0] rx_res;
  logic [3:0]  nxt_nib;
  logic        tick;

  assign tick    = (cnt == DIV_M1);
  // After rising edge k the next nibble is index k: byte k/2, high nibble on even k.
  assign nxt_nib = ops[{edge_cnt[3:1], ~edge_cnt[0], 2'b00} +: 4];
  assign rx_res  = {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      ops         <= '0;
      rx_sh       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      qspi_clk_o  <= 1'b0;
      qspi_cs_n_o <= 1'b1;
      qspi_io_o   <= '0;
      qspi_io_oe  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ops         <= {b_in, a_in};
          qspi_io_o   <= a_in[7:4];
          qspi_io_oe  <= 4'hF;
          qspi_cs_n_o <= 1'b0;
          busy        <= 1'b1;
          cnt         <= '0;
          edge_cnt    <= '0;
          state       <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == SETUP_M1) begin
            cnt   <= '0;
            state <= S_TX;
          end else cnt <= cnt + 16'd1;
        end
        S_TX, S_RX, S_TAIL: begin
          if (!tick) cnt <= cnt + 16'd1;
          else begin
            cnt <= '0;
            if (!qspi_clk_o) begin
              // TAIL's final low half-period ends the frame instead of rising again.
              if (state == S_TAIL) begin
                qspi_cs_n_o <= 1'b1;
                state       <= S_GAP;
              end else begin
                qspi_clk_o <= 1'b1;
                edge_cnt   <= edge_cnt + 5'd1;
                if (state == S_RX) rx_sh <= {rx_sh[27:0], qspi_io_i};
                if (edge_cnt == 5'd23) state <= S_TAIL;
              end
            end else begin
              qspi_clk_o <= 1'b0;
              if (state == S_TX) begin
                if (edge_cnt == 5'd16) begin
                  qspi_io_oe <= '0;
                  qspi_io_o  <= '0;
                  state      <= S_RX;
                end else qspi_io_o <= nxt_nib;
              end
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_M1) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            result <= rx_res;
            state  <= S_IDLE;
          end else cnt <= cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef QSPI_HOST_CHECK_EN
  function automatic logic [7:0] mac(input logic [7:0] x0, y0, x1, y1);
    return x0 * y0 + x1 * y1;
  endfunction

  logic [31:0] exp_c;
  // ops bytes: A0..A3 at [7:0]..[31:24], B0..B3 at [39:32]..[63:56].
  assign exp_c = {mac(ops[23:16], ops[47:40], ops[31:24], ops[63:56]),
                  mac(ops[23:16], ops[39:32], ops[31:24], ops[55:48]),
                  mac(ops[7:0],   ops[47:40], ops[15:8],  ops[63:56]),
                  mac(ops[7:0],   ops[39:32], ops[15:8],  ops[55:48])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch <= 1'b0;
    else if (state == S_GAP && cnt == GAP_M1) mismatch <= (rx_res != exp_c);
  end
`endif
endmodule

// File: tb/tb_qspi_matmul_host.sv
// Bench for qspi_matmul_host: timeline model of the frame, behavioural QSPI target, random transfers.
module tb_qspi_matmul_host;
  localparam int D   = 4;
  localparam int S   = 4;
  localparam int G   = 4;
  localparam int TOT = S + 49 * D + G;  // cycles from cs_n falling to done

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] result;
  logic        qspi_clk_o, qspi_cs_n_o;
  logic [3:0]  qspi_io_o, qspi_io_oe, qspi_io_i;
`ifdef QSPI_HOST_CHECK_EN
  logic        mismatch;
`endif
  logic        corrupt;

  int checks = 0;
  int errors = 0;

  qspi_matmul_host #(.CLK_DIV(D), .CS_SETUP_CYC(S), .CS_GAP_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result),
    .qspi_clk_o(qspi_clk_o), .qspi_cs_n_o(qspi_cs_n_o), .qspi_io_o(qspi_io_o),
    .qspi_io_oe(qspi_io_oe), .qspi_io_i(qspi_io_i)
`ifdef QSPI_HOST_CHECK_EN
    , .mismatch(mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += int'(a[(2*i+k)*8 +: 8]) * int'(b[(2*k+j)*8 +: 8]);
        r[(2*i+j)*8 +: 8] = s[7:0];
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural target ----------------
  logic        t_prev;
  logic [4:0]  t_cnt;
  logic [63:0] t_ops;
  logic [31:0] t_a, t_b, t_c;
  logic [3:0]  t_nib;

  always_comb begin
    t_a = '0;
    t_b = '0;
    for (int i = 0; i < 4; i++) begin
      t_a[8*i +: 8] = t_ops[63-8*i -: 8];
      t_b[8*i +: 8] = t_ops[31-8*i -: 8];
    end
    t_c = mm(t_a, t_b);
  end

  always_comb begin
    int j;
    t_nib = '0;
    j = int'(t_cnt) - 16;
    if (j >= 0 && j < 8) t_nib = (j % 2 == 0) ? t_c[(j/2)*8+4 +: 4] : t_c[(j/2)*8 +: 4];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_prev <= 1'b0; t_cnt <= '0; t_ops <= '0; qspi_io_i <= '0;
    end else begin
      t_prev <= qspi_clk_o;
      if (qspi_cs_n_o) begin
        t_cnt <= '0; qspi_io_i <= '0;
      end else if (qspi_clk_o && !t_prev) begin
        if (t_cnt < 5'd16) t_ops <= {t_ops[59:0], qspi_io_o};
        t_cnt <= t_cnt + 5'd1;
      end else if (!qspi_clk_o && t_prev && t_cnt >= 5'd16 && t_cnt < 5'd24)
        qspi_io_i <= t_nib ^ ((corrupt && t_cnt == 5'd19) ? 4'h1 : 4'h0);
    end
  end

  // ---------------- timeline model of the host ----------------
  int          m_n = -1;   // cycles since accept edge, -1 when idle
  logic [31:0] m_a, m_b, m_res;
  logic        m_cor, m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= -1; m_res <= '0; m_mis <= 1'b0; m_a <= '0; m_b <= '0; m_cor <= 1'b0;
    end else if ((m_n < 0 || m_n >= TOT) && start) begin
      m_n <= 0; m_a <= a_in; m_b <= b_in; m_cor <= corrupt;
    end else if (m_n >= 0 && m_n < TOT) begin
      m_n <= m_n + 1;
      if (m_n == TOT - 1) begin
        m_res <= mm(m_a, m_b) ^ (m_cor ? 32'h100 : 32'h0);
        m_mis <= m_cor;
      end
    end else m_n <= -1;
  end

  // One compare per cycle of every output against the timeline
  initial begin
    int n, k, rises;
    logic pclk, pcs;
    logic [63:0] ops;
    logic e_busy, e_done, e_cs, e_sclk;
    logic [3:0] e_oe, e_io;
    rises = 0; pclk = 1'b0; pcs = 1'b1;
    forever begin
      @(negedge clk);
      n = m_n;
      ops = {m_b, m_a};
      e_busy = (n >= 0 && n < TOT);
      e_done = (n == TOT);
      e_cs   = !(n >= 0 && n < S + 49 * D);
      e_sclk = (n >= S && n < S + 48 * D && ((n - S) % (2 * D)) >= D);
      e_oe   = (n >= 0 && n < S + 32 * D) ? 4'hF : 4'h0;
      e_io   = 4'h0;
      if (n >= 0 && n < S + 32 * D) begin
        k = (n < S) ? 0 : (n - S) / (2 * D);
        e_io = ops[(k/2)*8 + ((k % 2 == 0) ? 4 : 0) +: 4];
      end
      chk("outputs", {busy, done, qspi_cs_n_o, qspi_clk_o, qspi_io_oe, qspi_io_o, result},
          {e_busy, e_done, e_cs, e_sclk, e_oe, e_io, m_res});
`ifdef QSPI_HOST_CHECK_EN
      chk("mismatch_track", {63'd0, mismatch}, {63'd0, m_mis});
`endif
      if (!rst_n) begin
        rises = 0; pcs = 1'b1; pclk = 1'b0;
      end else begin
        if (!qspi_cs_n_o && qspi_clk_o && !pclk) rises++;
        if (qspi_cs_n_o && !pcs) begin
          chk("rises_per_frame", 64'(rises), 64'd24);
          rises = 0;
        end
        pclk = qspi_clk_o; pcs = qspi_cs_n_o;
      end
    end
  end

  // mode 0: one-cycle start, 1: start held while busy, 2: random start pulses while busy
  task automatic xfer(input logic [31:0] a, input logic [31:0] b, input logic cor,
                      input int mode, output logic [31:0] res);
    int k, nb;
    @(negedge clk);
    a_in = a; b_in = b; corrupt = cor; start = 1'b1;
    k = 0; nb = 0; res = 'x;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (done) break;
      a_in = $urandom; b_in = $urandom;
      start = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    start = 1'b0;
    chk("done_latency", 64'(k), 64'(TOT + 1));
    chk("busy_cycles", 64'(nb), 64'(TOT));
    res = result;
  endtask

  initial begin
    logic [31:0] r, a, b;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, qspi_cs_n_o, qspi_clk_o, qspi_io_oe, qspi_io_o, result},
        {1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0});
    rst_n = 1'b1;
    @(negedge clk);

    xfer(32'h01000001, 32'h08070605, 1'b0, 0, r);
    chk("identity_times_b", 64'(r), 64'h08070605);
    xfer(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, r);
    chk("all_ff", 64'(r), 64'h02020202);
    xfer(32'h78563412, 32'hF0DEBC9A, 1'b0, 0, r);
    chk("nibble_order_case", 64'(r), 64'hA8CCF8EC);
    xfer(32'h04030201, 32'h01010101, 1'b0, 1, r);
    chk("start_held", 64'(r), 64'h07070303);
    repeat (3) @(negedge clk);
    chk("no_reaccept", {62'd0, busy, done}, 64'd0);

    // Abort mid-write with an asynchronous reset between clock edges
    @(negedge clk);
    a_in = 32'h11223344; b_in = 32'h55667788; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (84) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_abort", {59'd0, qspi_cs_n_o, qspi_clk_o, qspi_io_oe == 4'h0, busy, done},
           {59'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(32'h11223344, 32'h55667788, 1'b0, 0, r);
    chk("after_abort", 64'(r), 64'(mm(32'h11223344, 32'h55667788)));

    xfer(32'h01000001, 32'h08070605, 1'b1, 0, r);
    chk("corrupt_result", 64'(r), 64'h08070705);
`ifdef QSPI_HOST_CHECK_EN
    chk("mismatch_set", {63'd0, mismatch}, 64'd1);
`endif
    xfer(32'h01000001, 32'h08070605, 1'b0, 0, r);
`ifdef QSPI_HOST_CHECK_EN
    chk("mismatch_clear", {63'd0, mismatch}, 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      xfer(a, b, 1'b0, 2, r);
      chk("random_result", 64'(r), 64'(mm(a, b)));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
